// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM fade controller.
package pwm_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // A zero step size in a command is promoted to this value.
  localparam int unsigned STEP_MIN = 1;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Fade command channel between a command source (master) and the controller (slave).
interface pwm_fade_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int IVL_W = 8
);
  // Valid/ready: a command transfers on a rising edge where cmd_valid and cmd_ready
  // are both high; the master holds the fields stable while cmd_valid is high.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic [WIDTH-1:0] cmd_step;
  logic [IVL_W-1:0] cmd_interval;

  modport master (output cmd_valid, output cmd_target, output cmd_step,
                  output cmd_interval, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_target, input cmd_step,
                  input cmd_interval, output cmd_ready);
endinterface

// File: rtl/dffr.sv
// Team D flip-flop with synchronous active-high reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/pwm.sv
// Free-running PWM generator: output high while its counter is below duty.
module pwm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_signal
);
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;

  assign cnt_nxt = cnt + WIDTH'(1);

  dffr #(.W(WIDTH)) u_cnt (.clk(clk), .reset(reset), .d(cnt_nxt), .q(cnt));

  assign pwm_signal = (cnt < duty);
endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM fade controller: steps duty toward a commanded target once every
// (interval+1) PWM periods, changing duty only at period boundaries.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IVL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  pwm_fade_ctrl_if.slave   cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] duty,
  output logic             pwm_signal,
  output logic             period_start,
  output logic             busy,
  output logic             done,
  output state_t           state
);

  logic [WIDTH-1:0] period_cnt, period_cnt_nxt;
  logic [WIDTH-1:0] tgt_q, step_q, duty_n, tgt_n, step_n, stepped, cmd_step_eff;
  logic [IVL_W-1:0] ivl_q, ivl_n, ivl_cnt, ivl_cnt_n;
  logic [0:0]       state_q;
  state_t           state_n;
  logic             done_n, accept, boundary;

  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] stp);
    // Compare the remaining distance first so the add/subtract can never wrap.
    if (tgt > cur) return ((tgt - cur) <= stp) ? tgt : cur + stp;
    else           return ((cur - tgt) <= stp) ? tgt : cur - stp;
  endfunction

  assign state          = state_t'(state_q);
  assign busy           = (state == RAMP);
  assign cmd.cmd_ready  = (state == IDLE) && !reset;
  assign accept         = cmd.cmd_valid && cmd.cmd_ready;
  assign boundary       = (period_cnt == '1);
  assign period_start   = (period_cnt == '0);
  assign period_cnt_nxt = period_cnt + WIDTH'(1);
  assign cmd_step_eff   = (cmd.cmd_step == '0) ? WIDTH'(STEP_MIN) : cmd.cmd_step;
  assign stepped        = step_toward(duty, tgt_q, step_q);

  always_comb begin
    state_n   = state;
    duty_n    = duty;
    tgt_n     = tgt_q;
    step_n    = step_q;
    ivl_n     = ivl_q;
    ivl_cnt_n = ivl_cnt;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_n     = cmd.cmd_target;
          step_n    = cmd_step_eff;
          ivl_n     = cmd.cmd_interval;
          ivl_cnt_n = cmd.cmd_interval;
          if (cmd.cmd_target == duty) done_n  = 1'b1;
          else                        state_n = RAMP;
        end
      end
      RAMP: begin
        // abort outranks a step falling due in the same boundary cycle
        if (abort) begin
          state_n = IDLE;
        end else if (boundary) begin
          if (ivl_cnt == '0) begin
            duty_n    = stepped;
            ivl_cnt_n = ivl_q;
            if (stepped == tgt_q) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end else begin
            ivl_cnt_n = ivl_cnt - IVL_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  dffr #(.W(1))     u_state   (.clk(clk), .reset(reset), .d(state_n),        .q(state_q));
  dffr #(.W(WIDTH)) u_duty    (.clk(clk), .reset(reset), .d(duty_n),         .q(duty));
  dffr #(.W(WIDTH)) u_tgt     (.clk(clk), .reset(reset), .d(tgt_n),          .q(tgt_q));
  dffr #(.W(WIDTH)) u_step    (.clk(clk), .reset(reset), .d(step_n),         .q(step_q));
  dffr #(.W(IVL_W)) u_ivl     (.clk(clk), .reset(reset), .d(ivl_n),          .q(ivl_q));
  dffr #(.W(IVL_W)) u_ivl_cnt (.clk(clk), .reset(reset), .d(ivl_cnt_n),      .q(ivl_cnt));
  dffr #(.W(1))     u_done    (.clk(clk), .reset(reset), .d(done_n),         .q(done));
  dffr #(.W(WIDTH)) u_period  (.clk(clk), .reset(reset), .d(period_cnt_nxt), .q(period_cnt));

  // Shares reset with the period counter above, so both count in lockstep.
  pwm #(.WIDTH(WIDTH)) u_pwm (
    .clk       (clk),
    .reset     (reset),
    .duty      (duty),
    .pwm_signal(pwm_signal)
  );

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl at WIDTH=4: directed vector table, corner sequences
// and randomized fades checked against an arithmetic fade model.
module tb_pwm_fade_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int W  = 4;
  localparam int IW = 4;
  localparam int P  = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         abort = 1'b0;
  logic [W-1:0] duty;
  logic         pwm_signal, period_start, busy, done;
  state_t       state;

  pwm_fade_ctrl_if #(.WIDTH(W), .IVL_W(IW)) cmd_if ();

  pwm_fade_ctrl #(.WIDTH(W), .IVL_W(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .abort       (abort),
    .duty        (duty),
    .pwm_signal  (pwm_signal),
    .period_start(period_start),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           n_checks = 0;
  int           n_fail = 0;
  int           model_duty = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int tgt;
    int step;
    int ivl;
    int busy_cmd;
    int abort_cmd;
    int exp_steps;
    int exp_final;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ps(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * P; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no period_start, expected one within %0d cycles", name, 3 * P);
  endtask

  // Duty after j applied steps: saturating linear move toward the target.
  function automatic int model_after(input int d0, input int tgt, input int s, input int j);
    int v;
    if (tgt > d0) begin
      v = d0 + j * s;
      if (v > tgt) v = tgt;
    end else begin
      v = d0 - j * s;
      if (v < tgt) v = tgt;
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue_cmd(input int tgt, input int step, input int ivl, input int with_abort);
    check("cmd_ready_idle", int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_target   = tgt[W-1:0];
    cmd_if.cmd_step     = step[W-1:0];
    cmd_if.cmd_interval = ivl[IW-1:0];
    abort               = (with_abort != 0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    abort            = 1'b0;
  endtask

  task automatic run_fade(input string name, input int tgt, input int step, input int ivl,
                          input int busy_cmd, input int abort_cmd,
                          input int exp_steps, input int exp_final);
    int d0, s, nsteps, total_k, high, changes, prev, k, last_e;
    bit ok, spurious;
    logic [W-1:0] e;
    d0      = model_duty;
    s       = (step == 0) ? 1 : step;
    nsteps  = (((tgt > d0) ? tgt - d0 : d0 - tgt) + s - 1) / s;
    total_k = (ivl + 1) * nsteps;
    exp_q.delete();
    for (int kk = 1; kk <= total_k + 1; kk++)
      exp_q.push_back(W'(model_after(d0, tgt, s, kk / (ivl + 1))));
    wait_ps(name, ok);
    if (!ok) return;
    issue_cmd(tgt, step, ivl, abort_cmd);
    check({name, "_busy"}, int'(busy), 1);
    high = 0; changes = 0; prev = d0; spurious = 1'b0; last_e = d0;
    for (int c = 1; c <= (total_k + 1) * P; c++) begin
      if (c > 1) @(negedge clk);
      k = c / P;
      if (busy_cmd != 0 && c >= 2 && c <= 6) begin
        check({name, "_ready_busy"}, int'(cmd_if.cmd_ready), 0);
        cmd_if.cmd_valid  = (c < 6);
        cmd_if.cmd_target = ~tgt[W-1:0];
      end
      if (c % P == 0) begin
        if (k >= 2) check({name, "_pwm_high"}, high, last_e);
        e = exp_q.pop_front();
        check({name, "_period_start"}, int'(period_start), 1);
        check({name, "_duty"}, int'(duty), int'(e));
        check({name, "_done"}, int'(done), int'(k == total_k));
        if (k == total_k) check({name, "_busy_end"}, int'(busy), 0);
        if (int'(duty) != prev) changes++;
        prev   = int'(duty);
        last_e = int'(e);
        high   = 0;
      end else if (done) begin
        spurious = 1'b1;
      end
      high += int'(pwm_signal);
    end
    check({name, "_no_extra_done"}, int'(spurious), 0);
    if (exp_steps >= 0) begin
      check({name, "_steps"}, changes, exp_steps);
      check({name, "_final"}, int'(duty), exp_final);
    end
    model_duty = tgt;
  endtask

  task automatic start_far(input string name, output int far, output bit ok);
    far = (model_duty < 8) ? 15 : 0;
    wait_ps(name, ok);
    if (!ok) return;
    issue_cmd(far, 1, 0, 0);
  endtask

  task automatic equal_target();
    @(negedge clk);
    check("eq_ready", int'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_target   = model_duty[W-1:0];
    cmd_if.cmd_step     = 4'd2;
    cmd_if.cmd_interval = '0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("eq_done", int'(done), 1);
    check("eq_busy", int'(busy), 0);
    check("eq_state", int'(state), int'(IDLE));
    @(negedge clk);
    check("eq_done_once", int'(done), 0);
    check("eq_duty", int'(duty), model_duty);
  endtask

  task automatic abort_mid();
    int far, held;
    bit ok, spurious;
    start_far("abort_mid", far, ok);
    if (!ok) return;
    repeat (36) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    held  = model_duty + ((far > model_duty) ? 2 : -2);
    check("abort_busy", int'(busy), 0);
    check("abort_state", int'(state), int'(IDLE));
    check("abort_duty", int'(duty), held);
    spurious = 1'b0;
    for (int c = 39; c < 39 + 3 * P; c++) begin
      @(negedge clk);
      if (done) spurious = 1'b1;
      if (c % P == 0) check("abort_hold", int'(duty), held);
    end
    check("abort_no_done", int'(spurious), 0);
    model_duty = held;
  endtask

  task automatic abort_boundary();
    int far;
    bit ok;
    start_far("abort_bnd", far, ok);
    if (!ok) return;
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_bnd_duty", int'(duty), model_duty);
    check("abort_bnd_busy", int'(busy), 0);
    check("abort_bnd_done", int'(done), 0);
    check("abort_bnd_ps", int'(period_start), 1);
  endtask

  task automatic reset_mid();
    int far;
    bit ok;
    start_far("reset_mid", far, ok);
    if (!ok) return;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_duty", int'(duty), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(cmd_if.cmd_ready), 0);
    check("rst_mid_pwm", int'(pwm_signal), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_ready_after", int'(cmd_if.cmd_ready), 1);
    check("rst_mid_ps", int'(period_start), 1);
    check("rst_mid_state", int'(state), int'(IDLE));
    model_duty = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r_tgt, r_step, r_ivl, r_busy, r_abort;
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_target   = '0;
    cmd_if.cmd_step     = '0;
    cmd_if.cmd_interval = '0;

    repeat (3) @(negedge clk);
    check("rst_ready_low", int'(cmd_if.cmd_ready), 0);
    reset = 1'b0;
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_pwm", int'(pwm_signal), 0);
    check("rst_ready", int'(cmd_if.cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ps", int'(period_start), 1);

    //          tgt step ivl busy abort steps final
    vecs[0] = '{10,  4,  0,  0,   0,    3,    10};
    vecs[1] = '{ 3,  3,  1,  1,   0,    3,     3};
    vecs[2] = '{ 1,  0,  0,  0,   1,    2,     1};
    vecs[3] = '{ 5,  4,  0,  0,   0,    1,     5};
    vecs[4] = '{14, 15,  0,  0,   0,    1,    14};
    vecs[5] = '{15, 15,  0,  0,   0,    1,    15};
    vecs[6] = '{ 0, 15,  1,  0,   0,    1,     0};

    for (int i = 0; i < 7; i++) begin
      if (i == 4) equal_target();
      run_fade($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].step, vecs[i].ivl,
               vecs[i].busy_cmd, vecs[i].abort_cmd, vecs[i].exp_steps, vecs[i].exp_final);
    end

    abort = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle_state", int'(state), int'(IDLE));
    check("abort_idle_duty", int'(duty), model_duty);
    abort = 1'b0;

    abort_mid();
    abort_boundary();
    reset_mid();

    for (int r = 0; r < 12; r++) begin
      r_tgt = int'($urandom_range(0, 15));
      if (r_tgt == model_duty) r_tgt = r_tgt ^ 1;
      r_step  = int'($urandom_range(0, 15));
      r_ivl   = int'($urandom_range(0, 1));
      r_busy  = int'($urandom_range(0, 1));
      r_abort = int'($urandom_range(0, 1));
      run_fade($sformatf("rand%0d", r), r_tgt, r_step, r_ivl, r_busy, r_abort, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: duty and period-counter resolution; period = 2^WIDTH clk cycles.
REQ-002 Parameter IVL_W, default 8: width of the step-interval field.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  fade command present.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_target  input  WIDTH  final duty value.
REQ-008 cmd_step  input  WIDTH  duty change per update; 0 is treated as 1.
REQ-009 cmd_interval  input  IVL_W  periods between updates, minus 1.
REQ-010 abort  input  1  stop the active fade and hold the current duty.
REQ-011 duty  output  WIDTH  registered duty value driven to the PWM.
REQ-012 pwm_signal  output  1  PWM output: high while the period counter is less than duty.
REQ-013 period_start  output  1  high in the cycle where the period counter = 0.
REQ-014 busy  output  1  high while in RAMP.
REQ-015 done  output  1  one-cycle pulse when a fade completes.

Function
REQ-016 The block SHALL have two states: IDLE and RAMP.
REQ-017 cmd_ready SHALL be high only in IDLE with reset low.
REQ-018 A command SHALL be accepted when cmd_valid and cmd_ready are both high; target, step (0 changed to 1) and interval SHALL be latched, and the interval counter SHALL be loaded with cmd_interval.
REQ-019 On acceptance with cmd_target equal to duty, the block SHALL stay in IDLE and pulse done in the next cycle.
REQ-020 On acceptance with cmd_target not equal to duty, the state SHALL go to RAMP.
REQ-021 The period counter SHALL be free-running over 0..2^WIDTH-1 and SHALL wrap to 0.
REQ-022 The boundary cycle SHALL be the cycle where the period counter = 2^WIDTH-1.
REQ-023 In RAMP, at each boundary cycle: if the interval counter is 0, the block SHALL apply one step and reload the interval counter; otherwise it SHALL decrement the interval counter.
REQ-024 A new duty value SHALL take effect only on the clock edge that ends a boundary cycle, so each period uses a single duty value (glitch-free).
REQ-025 Step rule when moving upward: if target - duty <= step, duty SHALL become target; otherwise duty SHALL become duty + step.
REQ-026 Step rule when moving downward: if duty - target <= step, duty SHALL become target; otherwise duty SHALL become duty - step.
REQ-027 All step arithmetic SHALL be unsigned WIDTH-bit with no overflow or underflow.
REQ-028 When duty reaches target, the state SHALL return to IDLE and done SHALL be high for exactly the first cycle of the new period (period_start = 1).
REQ-029 abort in RAMP SHALL move the state to IDLE on the next edge, hold duty, and produce no done pulse.
REQ-030 abort in IDLE SHALL be ignored; abort asserted together with an accepted command SHALL be ignored.
REQ-031 If abort arrives in a boundary cycle whose step is due, abort SHALL win and duty SHALL stay unchanged.
REQ-032 In RAMP, cmd_valid SHALL be ignored (cmd_ready is low).

Reset
REQ-033 reset SHALL set: state IDLE, duty 0, period counter 0, interval counter 0, done 0, busy 0, pwm_signal 0.
REQ-034 reset SHALL take priority over abort and commands, including during a RAMP.
REQ-035 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-036 The state encoding and step-rule constants SHALL live in the shared pwm_ctrl_pkg package/include.
REQ-037 pwm_signal SHALL be produced by one instance of the existing pwm sub-module, fed by duty and reset together with the controller so its counter stays aligned with the period counter.
REQ-038 Registers SHALL use the team's dffr flop.

Verification (bench WIDTH=4, period 16)
REQ-039 Reset: release reset -> duty=0, pwm_signal=0, cmd_ready=1, busy=0.
REQ-040 Upward fade: duty 0, cmd target=10, step=4, interval=0 -> duty reads 4, 8, 10 at three consecutive period_starts; done once with the 10; pwm high 4/8/10 cycles per period.
REQ-041 Downward fade with interval and zero step:
- duty 10, target=3, step=3, interval=1 -> duty 7, 4, 3, each after 2 periods.
- step=0 -> steps of 1.
REQ-042 Target equals duty: duty=5, target=5 -> no RAMP, done the next cycle.
REQ-043 Abort and busy commands: abort mid-fade -> IDLE, duty held, no done; cmd_valid while busy -> not accepted.
REQ-044 Edge cases:
- reset mid-fade -> duty 0, IDLE.
- duty 14, target 15, step 15 -> 15 with no wrap; pwm high 15 of 16 cycles.
